// File: rtl/if_fetch_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | if_fetch_if : pipeline, redirect and byte-memory bundle for if_fetch |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface if_fetch_if;
  logic [5:0]  stall;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        if_flag;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_if;

  modport master (
    input  stall, branch_flag, branch_target, mem_ack, mem_rdata,
    output mem_req, mem_addr, if_flag, if_pc, if_inst, stallreq_if
  );

  modport slave (
    output stall, branch_flag, branch_target, mem_ack, mem_rdata,
    input  mem_req, mem_addr, if_flag, if_pc, if_inst, stallreq_if
  );
endinterface
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | if_fetch : byte-serial instruction fetch, assembles 32-bit LE words  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module if_fetch (
  input  logic       clk,
  input  logic       rst,
  if_fetch_if.master bus
);

  localparam logic [2:0] S_B0    = 3'd0;
  localparam logic [2:0] S_B1    = 3'd1;
  localparam logic [2:0] S_B2    = 3'd2;
  localparam logic [2:0] S_B3    = 3'd3;
  localparam logic [2:0] S_VALID = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [23:0] buf_q, buf_d;
  logic        if_flag_q, if_flag_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;

  logic        hold;
  logic        fetching;
  logic [4:0]  unused_stall;

  assign hold         = bus.stall[0];
  assign unused_stall = bus.stall[5:1];
  assign fetching     = (state_q != S_VALID);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_B0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a redirect wins over any ack or hold
  always_comb begin
    state_d = state_q;
    if (bus.branch_flag) begin
      state_d = S_B0;
    end else begin
      case (state_q)
        S_B0:    if (bus.mem_ack) state_d = S_B1;
        S_B1:    if (bus.mem_ack) state_d = S_B2;
        S_B2:    if (bus.mem_ack) state_d = S_B3;
        S_B3:    if (bus.mem_ack) state_d = S_VALID;
        S_VALID: if (!hold)       state_d = S_B0;
        default: state_d = S_B0;
      endcase
    end
  end

  // Memory-side outputs; the byte offset is the low bits of the state code
  always_comb begin
    bus.mem_req     = 1'b0;
    bus.mem_addr    = 32'd0;
    bus.stallreq_if = 1'b0;
    if (rst && fetching) begin
      bus.mem_req     = 1'b1;
      bus.mem_addr    = pc_q + {30'd0, state_q[1:0]};
      bus.stallreq_if = 1'b1;
    end
  end

  always_comb begin
    pc_d      = pc_q;
    buf_d     = buf_q;
    if_flag_d = if_flag_q;
    if_pc_d   = if_pc_q;
    if_inst_d = if_inst_q;
    if (bus.branch_flag) begin
      pc_d      = {bus.branch_target[31:2], 2'b00};
      buf_d     = 24'd0;
      if_flag_d = 1'b0;
      if_pc_d   = 32'd0;
      if_inst_d = 32'd0;
    end else begin
      case (state_q)
        S_B0: if (bus.mem_ack) buf_d[7:0]   = bus.mem_rdata;
        S_B1: if (bus.mem_ack) buf_d[15:8]  = bus.mem_rdata;
        S_B2: if (bus.mem_ack) buf_d[23:16] = bus.mem_rdata;
        S_B3: begin
          if (bus.mem_ack) begin
            if_inst_d = {bus.mem_rdata, buf_q};
            if_pc_d   = pc_q + 32'd4;
            if_flag_d = 1'b1;
          end
        end
        S_VALID: begin
          if (!hold) begin
            pc_d      = pc_q + 32'd4;
            if_flag_d = 1'b0;
            if_pc_d   = 32'd0;
            if_inst_d = 32'd0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q      <= 32'd0;
      buf_q     <= 24'd0;
      if_flag_q <= 1'b0;
      if_pc_q   <= 32'd0;
      if_inst_q <= 32'd0;
    end else begin
      pc_q      <= pc_d;
      buf_q     <= buf_d;
      if_flag_q <= if_flag_d;
      if_pc_q   <= if_pc_d;
      if_inst_q <= if_inst_d;
    end
  end

  assign bus.if_flag = if_flag_q;
  assign bus.if_pc   = if_pc_q;
  assign bus.if_inst = if_inst_q;

endmodule
`default_nettype wire

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-low reset (rst==0 at a rising edge resets).
REQ-003 SHALL have port stall, input, 6 bits: pipeline stall vector; only stall[0] (hold IF) is used.
REQ-004 SHALL have port branch_flag, input, 1 bit: redirect request from EX.
REQ-005 SHALL have port branch_target, input, 32 bits: redirect PC.
REQ-006 SHALL have port mem_req, output, 1 bit: byte-read request to memory controller.
REQ-007 SHALL have port mem_addr, output, 32 bits: byte address of the current request.
REQ-008 SHALL have port mem_ack, input, 1 bit: high in the cycle the controller returns a byte.
REQ-009 SHALL have port mem_rdata, input, 8 bits: returned byte, valid only when mem_ack==1.
REQ-010 SHALL have port if_flag, output, 1 bit: if_pc/if_inst hold a complete instruction.
REQ-011 SHALL have port if_pc, output, 32 bits: address of presented instruction plus 4.
REQ-012 SHALL have port if_inst, output, 32 bits: presented instruction, little-endian assembled.
REQ-013 SHALL have port stallreq_if, output, 1 bit: fetch in progress, request upstream stall.

Function
REQ-014 SHALL implement FSM states B0, B1, B2, B3 (fetching byte k), and VALID.
REQ-015 SHALL hold internal 32-bit pc and a 24-bit partial-instruction buffer.
REQ-016 In Bk, SHALL drive mem_req=1 and mem_addr=pc+k (32-bit wrap).
REQ-017 In VALID, SHALL drive mem_req=0 and mem_addr=0.
REQ-018 In Bk (k<3) with mem_ack=1, SHALL store mem_rdata into buffer bits [8k+7:8k] and advance to B(k+1).
REQ-019 In Bk with mem_ack=0, SHALL remain in Bk with the buffer unchanged.
REQ-020 In B3 with mem_ack=1, SHALL register if_inst={mem_rdata, buffer[23:0]}, if_pc=pc+4, if_flag=1, and enter VALID.
REQ-021 Latency: the edge capturing byte 3 asserts if_flag; minimum 5 cycles per instruction with ack every cycle.
REQ-022 In VALID with stall[0]=0, SHALL, at the next edge, set pc=pc+4, if_flag=0, if_pc=0, if_inst=0, and enter B0.
REQ-023 In VALID with stall[0]=1, SHALL hold state, pc, if_flag, if_pc and if_inst unchanged.
REQ-024 stall[0] SHALL NOT affect B0-B3; byte fetching continues.
REQ-025 branch_flag=1 in any state SHALL, at that edge:
  - set pc={branch_target[31:2],2'b00};
  - discard the buffer;
  - set if_flag=0, if_pc=0, if_inst=0;
  - enter B0.
REQ-026 branch_flag SHALL take priority over mem_ack and stall[0] in the same cycle; a byte acked that cycle is dropped.
REQ-027 stallreq_if SHALL be combinational: 1 in B0-B3, 0 in VALID and during reset.
REQ-028 pc+4 and pc+k SHALL wrap modulo 2^32 (0xFFFFFFFC+4=0).

Reset
REQ-029 rst==0 at an edge SHALL set pc=0, state=B0, buffer=0, if_flag=0, if_pc=0, if_inst=0; this overrides all other inputs.
REQ-030 Reset asserted mid-fetch or in VALID SHALL abandon the instruction; the first request after release is mem_addr=0.
REQ-031 While rst==0, mem_req SHALL be 0; in the first cycle after release, mem_req=1 and mem_addr=0.

Verification
REQ-032 Memory bytes 0..3 = 13,05,10,00 (hex), ack every cycle after reset release -> addresses 0,1,2,3 on cycles 1-4; if_flag=1 cycle 5 with if_inst=0x00100513, if_pc=0x4; next request addr 4 on cycle 6.
REQ-033 Ack delayed 3 cycles on byte 2 -> mem_addr held at 2 for 4 cycles; if_inst still assembled correctly; if_flag delayed 3 cycles.
REQ-034 stall[0]=1 for 4 cycles while in VALID -> if_flag, if_pc, if_inst stable for those cycles; mem_req=0; advance 1 cycle after stall[0] falls.
REQ-035 branch_flag=1 with target 0x103 during B2, mem_ack=1 same cycle -> next mem_addr=0x100, that byte dropped; subsequent if_pc=0x104.
REQ-036 Branch and stall[0] together in VALID -> if_flag=0 next cycle, fetch restarts at target.
REQ-037 pc preloaded via branch to 0xFFFFFFFC -> mem_addr sequence FFFFFFFC..FFFFFFFF; if_pc=0; next fetch at 0. rst=0 mid-fetch -> if_flag=0; restart at 0.
